// File: rtl/microwave_controller.sv
// Microwave oven controller: BCD mm:ss keypad entry, 1 Hz countdown, pause/resume
// with door interlock, and a timed end-of-cook beep. All outputs are registered.
module microwave_controller #(
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic       mag_on,
  output logic       light_on,
  output logic       done_beep,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CW = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);

  state_t        state_reg, state_next;
  logic [3:0]    min_t_reg, min_t_next, min_o_reg, min_o_next;
  logic [3:0]    sec_t_reg, sec_t_next, sec_o_reg, sec_o_next;
  logic [CW-1:0] beep_cnt_reg, beep_cnt_next;
  logic          mag_on_reg, mag_on_next;
  logic          light_on_reg, light_on_next;
  logic          done_beep_reg, done_beep_next;

  // Prioritised events: at most one is active per cycle.
  logic ev_stop, ev_door, ev_tick, ev_start, ev_key;
  always_comb begin
    ev_stop  = stop;
    ev_door  = !stop && !door_closed;
    ev_tick  = !stop && door_closed && tick_1hz;
    ev_start = !stop && door_closed && !tick_1hz && start;
    ev_key   = !stop && door_closed && !tick_1hz && !start && key_valid && (key_digit <= 4'd9);
  end

  // One-second BCD decrement with borrow chain.
  logic [3:0] dec_min_t, dec_min_o, dec_sec_t, dec_sec_o;
  logic       time_zero, dec_zero;
  always_comb begin
    dec_min_t = min_t_reg;
    dec_min_o = min_o_reg;
    dec_sec_t = sec_t_reg;
    dec_sec_o = sec_o_reg - 4'd1;
    if (sec_o_reg == 4'd0) begin
      dec_sec_o = 4'd9;
      dec_sec_t = sec_t_reg - 4'd1;
      if (sec_t_reg == 4'd0) begin
        dec_sec_t = 4'd5;
        dec_min_o = min_o_reg - 4'd1;
        if (min_o_reg == 4'd0) begin
          dec_min_o = 4'd9;
          dec_min_t = min_t_reg - 4'd1;
        end
      end
    end
    time_zero = ({min_t_reg, min_o_reg, sec_t_reg, sec_o_reg} == 16'h0000);
    dec_zero  = ({dec_min_t, dec_min_o, dec_sec_t, dec_sec_o} == 16'h0000);
  end

  always_comb begin
    state_next    = state_reg;
    min_t_next    = min_t_reg;
    min_o_next    = min_o_reg;
    sec_t_next    = sec_t_reg;
    sec_o_next    = sec_o_reg;
    beep_cnt_next = '0;

    case (state_reg)
      IDLE: begin
        {min_t_next, min_o_next, sec_t_next, sec_o_next} = 16'h0000;
        if (ev_key) begin
          sec_o_next = key_digit;
          state_next = SET;
        end
      end
      SET: begin
        if (ev_stop) begin
          {min_t_next, min_o_next, sec_t_next, sec_o_next} = 16'h0000;
          state_next = IDLE;
        end else if (ev_start) begin
          if (!time_zero && (sec_t_reg <= 4'd5)) state_next = COOK;
        end else if (ev_key) begin
          min_t_next = min_o_reg;
          min_o_next = sec_t_reg;
          sec_t_next = sec_o_reg;
          sec_o_next = key_digit;
        end
      end
      COOK: begin
        if (ev_stop || ev_door) begin
          state_next = PAUSE;
        end else if (ev_tick) begin
          if (time_zero) begin
            state_next = DONE;
          end else begin
            {min_t_next, min_o_next, sec_t_next, sec_o_next} =
              {dec_min_t, dec_min_o, dec_sec_t, dec_sec_o};
            if (dec_zero) state_next = DONE;
          end
        end
      end
      PAUSE: begin
        if (ev_stop) begin
          {min_t_next, min_o_next, sec_t_next, sec_o_next} = 16'h0000;
          state_next = IDLE;
        end else if (ev_start) begin
          state_next = COOK;
        end
      end
      DONE: begin
        {min_t_next, min_o_next, sec_t_next, sec_o_next} = 16'h0000;
        beep_cnt_next = beep_cnt_reg;
        if (ev_stop) begin
          beep_cnt_next = '0;
          state_next    = IDLE;
        end else if (ev_tick) begin
          if (beep_cnt_reg >= CW'(BEEP_TICKS - 1)) begin
            beep_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            beep_cnt_next = beep_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        {min_t_next, min_o_next, sec_t_next, sec_o_next} = 16'h0000;
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    mag_on_next    = (state_next == COOK);
    done_beep_next = (state_next == DONE);
    light_on_next  = (state_next == COOK || state_next == PAUSE) ? 1'b1 : !door_closed;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg     <= IDLE;
      min_t_reg     <= '0;
      min_o_reg     <= '0;
      sec_t_reg     <= '0;
      sec_o_reg     <= '0;
      beep_cnt_reg  <= '0;
      mag_on_reg    <= 1'b0;
      light_on_reg  <= 1'b0;
      done_beep_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      min_t_reg     <= min_t_next;
      min_o_reg     <= min_o_next;
      sec_t_reg     <= sec_t_next;
      sec_o_reg     <= sec_o_next;
      beep_cnt_reg  <= beep_cnt_next;
      mag_on_reg    <= mag_on_next;
      light_on_reg  <= light_on_next;
      done_beep_reg <= done_beep_next;
    end
  end

  assign state     = state_reg;
  assign min_t     = min_t_reg;
  assign min_o     = min_o_reg;
  assign sec_t     = sec_t_reg;
  assign sec_o     = sec_o_reg;
  assign mag_on    = mag_on_reg;
  assign light_on  = light_on_reg;
  assign done_beep = done_beep_reg;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller; snapshot = {state, mm:ss, mag, light, beep}.
module tb_microwave_controller;
  logic       clk = 1'b0;
  logic       clear = 1'b0, tick_1hz = 1'b0, key_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] key_digit = 4'd0;
  logic       mag_on, light_on, done_beep;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic [2:0] state;
  int checks = 0;
  int failures = 0;

  microwave_controller #(.BEEP_TICKS(3)) dut (
    .clk(clk), .clear(clear), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .stop(stop), .door_closed(door_closed),
    .mag_on(mag_on), .light_on(light_on), .done_beep(done_beep),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o), .state(state)
  );

  always #5 clk = ~clk;

  wire [21:0] obs = {state, min_t, min_o, sec_t, sec_o, mag_on, light_on, done_beep};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; step(); key_valid = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; key_valid = 1'b1; key_digit = 4'd5; start = 1'b1;
    step();
    clear = 1'b0; key_valid = 1'b0; start = 1'b0;
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL reset got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    $display("reset: obs=%h", obs);
  endtask

  task automatic test_cook_90();
    logic [21:0] exp;
    int s;
    key(4'd1); key(4'd3); key(4'd0);
    checks++; if (obs !== {3'd1, 16'h0130, 3'b000}) begin failures++; $display("FAIL set_0130 got=%h exp=%h", obs, {3'd1, 16'h0130, 3'b000}); end
    press_start();
    checks++; if (obs !== {3'd2, 16'h0130, 3'b110}) begin failures++; $display("FAIL cook_entry got=%h exp=%h", obs, {3'd2, 16'h0130, 3'b110}); end
    for (int i = 1; i <= 90; i++) begin
      tick();
      step();
      s = 90 - i;
      exp = {(s == 0) ? 3'd4 : 3'd2, 4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10),
             (s != 0), (s != 0), (s == 0)};
      checks++; if (obs !== exp) begin failures++; $display("FAIL countdown_%0d got=%h exp=%h", i, obs, exp); end
      if (i == 30 || i == 31 || i == 90) $display("countdown tick %0d: obs=%h", i, obs);
    end
    tick(); tick();
    checks++; if (obs !== {3'd4, 16'h0000, 3'b001}) begin failures++; $display("FAIL beep_hold got=%h exp=%h", obs, {3'd4, 16'h0000, 3'b001}); end
    tick();
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL beep_end got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    $display("beep end: obs=%h", obs);
  endtask

  task automatic test_set_shift();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    checks++; if (obs !== {3'd1, 16'h2345, 3'b000}) begin failures++; $display("FAIL shift_2345 got=%h exp=%h", obs, {3'd1, 16'h2345, 3'b000}); end
    key(4'd0); key(4'd7); key(4'd5);
    checks++; if (obs !== {3'd1, 16'h5075, 3'b000}) begin failures++; $display("FAIL shift_5075 got=%h exp=%h", obs, {3'd1, 16'h5075, 3'b000}); end
    press_start();
    checks++; if (obs !== {3'd1, 16'h5075, 3'b000}) begin failures++; $display("FAIL bad_sec_start got=%h exp=%h", obs, {3'd1, 16'h5075, 3'b000}); end
    key(4'd11);
    checks++; if (obs !== {3'd1, 16'h5075, 3'b000}) begin failures++; $display("FAIL set_bad_key got=%h exp=%h", obs, {3'd1, 16'h5075, 3'b000}); end
    press_stop();
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL set_stop got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    $display("set shift: obs=%h", obs);
  endtask

  task automatic test_pause();
    key(4'd1); key(4'd0); press_start();
    checks++; if (obs !== {3'd2, 16'h0010, 3'b110}) begin failures++; $display("FAIL pause_cook got=%h exp=%h", obs, {3'd2, 16'h0010, 3'b110}); end
    door_closed = 1'b0; tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    checks++; if (obs !== {3'd3, 16'h0010, 3'b010}) begin failures++; $display("FAIL door_pause got=%h exp=%h", obs, {3'd3, 16'h0010, 3'b010}); end
    press_start();
    checks++; if (obs !== {3'd3, 16'h0010, 3'b010}) begin failures++; $display("FAIL open_start got=%h exp=%h", obs, {3'd3, 16'h0010, 3'b010}); end
    door_closed = 1'b1; press_start();
    checks++; if (obs !== {3'd2, 16'h0010, 3'b110}) begin failures++; $display("FAIL resume got=%h exp=%h", obs, {3'd2, 16'h0010, 3'b110}); end
    tick();
    checks++; if (obs !== {3'd2, 16'h0009, 3'b110}) begin failures++; $display("FAIL resume_tick got=%h exp=%h", obs, {3'd2, 16'h0009, 3'b110}); end
    press_stop();
    checks++; if (obs !== {3'd3, 16'h0009, 3'b010}) begin failures++; $display("FAIL stop_pause got=%h exp=%h", obs, {3'd3, 16'h0009, 3'b010}); end
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL stop_start got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    $display("pause: obs=%h", obs);
  endtask

  task automatic test_priority_done_stop();
    key(4'd2);
    tick_1hz = 1'b1; start = 1'b1; step(); tick_1hz = 1'b0; start = 1'b0;
    checks++; if (obs !== {3'd1, 16'h0002, 3'b000}) begin failures++; $display("FAIL tick_over_start got=%h exp=%h", obs, {3'd1, 16'h0002, 3'b000}); end
    press_start(); tick();
    checks++; if (obs !== {3'd2, 16'h0001, 3'b110}) begin failures++; $display("FAIL cook_0001 got=%h exp=%h", obs, {3'd2, 16'h0001, 3'b110}); end
    tick();
    checks++; if (obs !== {3'd4, 16'h0000, 3'b001}) begin failures++; $display("FAIL done_entry got=%h exp=%h", obs, {3'd4, 16'h0000, 3'b001}); end
    tick();
    checks++; if (obs !== {3'd4, 16'h0000, 3'b001}) begin failures++; $display("FAIL done_1tick got=%h exp=%h", obs, {3'd4, 16'h0000, 3'b001}); end
    press_stop();
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL done_stop got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    $display("done stop: obs=%h", obs);
  endtask

  task automatic test_clear_mid_cook();
    key(4'd5); key(4'd0); key(4'd0); press_start();
    checks++; if (obs !== {3'd2, 16'h0500, 3'b110}) begin failures++; $display("FAIL cook_0500 got=%h exp=%h", obs, {3'd2, 16'h0500, 3'b110}); end
    clear = 1'b1; tick_1hz = 1'b1; start = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
    step();
    clear = 1'b0; tick_1hz = 1'b0; start = 1'b0; key_valid = 1'b0;
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL clear_cook got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    $display("clear mid cook: obs=%h", obs);
  endtask

  task automatic test_idle_misc();
    key(4'd12);
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL idle_bad_key got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    door_closed = 1'b0; step();
    checks++; if (obs !== {3'd0, 16'h0000, 3'b010}) begin failures++; $display("FAIL idle_light got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b010}); end
    door_closed = 1'b1; key(4'd4); press_start(); press_start();
    door_closed = 1'b0; tick(); door_closed = 1'b1;
    press_stop();
    checks++; if (obs !== {3'd0, 16'h0000, 3'b000}) begin failures++; $display("FAIL idle_cleanup got=%h exp=%h", obs, {3'd0, 16'h0000, 3'b000}); end
    $display("idle misc: obs=%h", obs);
  endtask

  initial begin
    test_reset();
    test_cook_90();
    test_set_shift();
    test_pause();
    test_priority_done_stop();
    test_clear_mid_cook();
    test_idle_misc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
